// File: rtl/stack_ctrl_if.sv
// ---------------------------------------------------------------------------
// stack_ctrl_if
// Command channel into the stack controller.
//   cmd_valid : command present
//   cmd_op    : 00 nop, 01 push, 10 pop, 11 replace
//   cmd_data  : operand for push / replace
//   cmd_ready : controller can take a command this cycle
// master = command issuer (core / testbench), slave = stack_ctrl.
// ---------------------------------------------------------------------------
interface stack_ctrl_if #(
    parameter int WIDTH = 16
) ();
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
// Stack controller for the Forth core's data/return stacks. The top two
// entries (TOS, NOS) live in registers; deeper entries spill to and refill
// from an external single-port RAM with a registered address (1-cycle read).
//
// Ports
//   clk_a        : clock, shared with RAM port a
//   rst          : asynchronous active-high reset
//   cmd_if       : command channel (valid/op/data/ready), slave side
//   clr_err_i    : clears sticky overflow/underflow (a same-cycle set wins)
//   tos_o, nos_o : registered top / next-on-stack
//   count_o      : occupancy 0..DEPTH+2
//   empty_o      : count == 0
//   full_o       : count == DEPTH+2
//   overflow_o   : sticky, push attempted while full
//   underflow_o  : sticky, pop attempted while empty
//   ram_addr_o   : RAM address (combinational)
//   ram_wdata_o  : RAM write data (always NOS)
//   ram_we_o     : RAM write enable (spill of NOS on push)
//   ram_rdata_i  : RAM read data, RAM[registered address]
// ---------------------------------------------------------------------------
module stack_ctrl #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 3)
) (
    input  logic                  clk_a,
    input  logic                  rst,
    stack_ctrl_if.slave           cmd_if,
    input  logic                  clr_err_i,
    output logic [WIDTH-1:0]      tos_o,
    output logic [WIDTH-1:0]      nos_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WIDTH-1:0]      ram_wdata_o,
    output logic                  ram_we_o,
    input  logic [WIDTH-1:0]      ram_rdata_i
);

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_TWO  = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]  CNT_FULL = CNT_WIDTH'(DEPTH + 2);
    localparam logic [ADDR_WIDTH:0]   SP_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    // ST_FETCH is the single bubble after a pop: the RAM address moved to
    // the new sp-1 and its data is not readable until the next cycle.
    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t                state_q,     state_d;
    logic [WIDTH-1:0]      tos_q,       tos_d;
    logic [WIDTH-1:0]      nos_q,       nos_d;
    logic [CNT_WIDTH-1:0]  count_q,     count_d;
    logic [ADDR_WIDTH:0]   sp_q,        sp_d;       // RAM-resident entries
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;

    logic accept;
    logic is_full;
    logic is_empty;

    assign accept   = cmd_if.cmd_valid && (state_q == ST_READY);
    assign is_full  = (count_q == CNT_FULL);
    assign is_empty = (count_q == CNT_ZERO);

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            state_q     <= ST_READY;
            tos_q       <= '0;
            nos_q       <= '0;
            count_q     <= '0;
            sp_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tos_q       <= tos_d;
            nos_q       <= nos_d;
            count_q     <= count_d;
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d     = ST_READY;
        tos_d       = tos_q;
        nos_d       = nos_q;
        count_d     = count_q;
        sp_d        = sp_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        ram_we_o    = 1'b0;
        // Idle address keeps RAM[sp-1] (the next refill value) on ram_rdata_i.
        ram_addr_o  = sp_q[ADDR_WIDTH-1:0] - ADDR_ONE;

        // Clear first so that an error raised below in the same cycle wins.
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (accept) begin
            case (cmd_if.cmd_op)
                OP_PUSH: begin
                    if (is_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        if (count_q == CNT_ZERO) begin
                            tos_d = cmd_if.cmd_data;
                        end else if (count_q == CNT_ONE) begin
                            nos_d = tos_q;
                            tos_d = cmd_if.cmd_data;
                        end else begin
                            // Spill NOS; the registered address then equals
                            // the new sp-1 and already holds the spilled
                            // word, so a following pop needs no bubble here.
                            ram_we_o   = 1'b1;
                            ram_addr_o = sp_q[ADDR_WIDTH-1:0];
                            nos_d      = tos_q;
                            tos_d      = cmd_if.cmd_data;
                            sp_d       = sp_q + SP_ONE;
                        end
                        count_d = count_q + CNT_ONE;
                    end
                end
                OP_POP: begin
                    state_d = ST_FETCH;
                    if (is_empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        if (count_q == CNT_ONE) begin
                            tos_d = '0;
                        end else if (count_q == CNT_TWO) begin
                            tos_d = nos_q;
                            nos_d = '0;
                        end else begin
                            tos_d = nos_q;
                            nos_d = ram_rdata_i;
                            sp_d  = sp_q - SP_ONE;
                        end
                        count_d = count_q - CNT_ONE;
                    end
                end
                OP_REPL: begin
                    tos_d = cmd_if.cmd_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_if.cmd_ready = (state_q == ST_READY);
    assign tos_o            = tos_q;
    assign nos_o            = nos_q;
    assign count_o          = count_q;
    assign empty_o          = is_empty;
    assign full_o           = is_full;
    assign overflow_o       = overflow_q;
    assign underflow_o      = underflow_q;
    assign ram_wdata_o      = nos_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl
// Drives stack_ctrl with directed and random commands, models the 512x16
// RAM (registered address, 1-cycle read) and compares every result against
// a queue-based stack model.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;

    localparam int W     = 16;
    localparam int D     = 512;
    localparam int AW    = 9;
    localparam int CW    = 10;
    localparam int FULLC = D + 2;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] REPL = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  tos, nos;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata, ram_rdata;
    logic          ram_we;

    stack_ctrl_if #(.WIDTH(W)) bus ();

    stack_ctrl dut (
        .clk_a       (clk),
        .rst         (rst),
        .cmd_if      (bus),
        .clr_err_i   (clr_err),
        .tos_o       (tos),
        .nos_o       (nos),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full),
        .overflow_o  (overflow),
        .underflow_o (underflow),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_we_o    (ram_we),
        .ram_rdata_i (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: address registered, data read from the array afterwards.
    logic [W-1:0]  mem [0:D-1];
    logic [AW-1:0] mem_addr_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        mem_addr_q <= ram_addr;
    end
    assign ram_rdata = mem[mem_addr_q];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the whole stack as a queue, top at the back.
    logic [W-1:0]  mq[$];
    logic [W-1:0]  m_etos;   // TOS value written by replace while empty
    bit            m_ov, m_un;
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  exp_wdata;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [W-1:0]  cap_wdata;

    function automatic logic [W-1:0] m_tos();
        return (mq.size() > 0) ? mq[mq.size()-1] : m_etos;
    endfunction

    function automatic logic [W-1:0] m_nos();
        return (mq.size() > 1) ? mq[mq.size()-2] : '0;
    endfunction

    function automatic logic [45:0] exp_state();
        return {m_tos(), m_nos(), CW'(mq.size()), (mq.size() == 0),
                (mq.size() == FULLC), m_ov, m_un};
    endfunction

    function automatic logic [45:0] dut_state();
        return {tos, nos, count, empty, full, overflow, underflow};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_etos = '0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
    endtask

    task automatic apply_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.cmd_data  = '0;
        clr_err       = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Issue one command (waiting out a stall), capture the RAM-side signals
    // mid-cycle, and advance the model.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] data, input bit clr);
        int guard = 0;
        int sz;
        bit set_ov, set_un;
        while (bus.cmd_ready !== 1'b1 && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: cmd_ready=%b required 1 within 8 cycles", bus.cmd_ready);
        end
        sz        = mq.size();
        exp_we    = (op == PUSH) && (sz >= 2) && (sz < FULLC);
        exp_addr  = AW'(sz - 2);
        exp_wdata = m_nos();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        clr_err       = clr;
        @(negedge clk);
        cap_we    = ram_we;
        cap_addr  = ram_addr;
        cap_wdata = ram_wdata;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        clr_err       = 1'b0;
        set_ov = (op == PUSH) && (sz == FULLC);
        set_un = (op == POP) && (sz == 0);
        case (op)
            PUSH: if (sz < FULLC) mq.push_back(data);
            POP:  if (sz > 0) begin
                      void'(mq.pop_back());
                      if (mq.size() == 0) m_etos = '0;
                  end
            REPL: if (sz > 0) mq[sz-1] = data; else m_etos = data;
            default: ;
        endcase
        m_ov = set_ov ? 1'b1 : (clr ? 1'b0 : m_ov);
        m_un = set_un ? 1'b1 : (clr ? 1'b0 : m_un);
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.cmd_data  = '0;
        rst = 1'b1;
        #3;
        n_cmp++;
        if ({dut_state(), bus.cmd_ready} !== {16'h0, 16'h0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", {dut_state(), bus.cmd_ready},
                     {16'h0, 16'h0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        apply_reset();
        n_cmp++;
        if (dut_state() !== exp_state() || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got %h rdy=%b required %h rdy=1", dut_state(), bus.cmd_ready, exp_state());
        end
    endtask

    task automatic test_push_basic();
        int we_cnt = 0;
        logic [AW-1:0] w_addr = '1;
        logic [W-1:0]  w_data = '0;
        logic [W-1:0]  vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            issue(PUSH, vals[i], 1'b0);
            if (cap_we === 1'b1) begin
                we_cnt++;
                w_addr = cap_addr;
                w_data = cap_wdata;
            end
        end
        n_cmp++;
        if ({tos, nos, count} !== {16'h3333, 16'h2222, 10'd3}) begin
            n_fail++;
            $display("FAIL push3_state: tos=%h nos=%h count=%0d required 3333 2222 3", tos, nos, count);
        end
        n_cmp++;
        if (we_cnt != 1 || w_addr !== 9'd0 || w_data !== 16'h1111) begin
            n_fail++;
            $display("FAIL push3_spill: pulses=%0d addr=%h wdata=%h required 1 000 1111", we_cnt, w_addr, w_data);
        end
    endtask

    task automatic test_pop_stall();
        issue(POP, '0, 1'b0);
        n_cmp++;
        if ({tos, nos, count} !== {16'h2222, 16'h1111, 10'd2}) begin
            n_fail++;
            $display("FAIL pop1_state: tos=%h nos=%h count=%0d required 2222 1111 2", tos, nos, count);
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pop1_stall: cmd_ready=%b required 0", bus.cmd_ready);
        end
        issue(POP, '0, 1'b0);
        n_cmp++;
        if ({tos, nos, count} !== {16'h1111, 16'h0000, 10'd1}) begin
            n_fail++;
            $display("FAIL pop2_state: tos=%h nos=%h count=%0d required 1111 0000 1", tos, nos, count);
        end
    endtask

    task automatic test_pop_stream();
        int   n_acc = 0;
        logic acc;
        apply_reset();
        for (int i = 0; i < 4; i++) issue(PUSH, W'($urandom), 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = POP;
        for (int i = 0; i < 8; i++) begin
            acc = bus.cmd_ready;
            n_cmp++;
            if (acc !== (i % 2 == 0)) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: cmd_ready=%b required %b", i, acc, (i % 2 == 0));
            end
            @(posedge clk); #1;
            if (acc === 1'b1) begin
                n_acc++;
                if (mq.size() > 0) void'(mq.pop_back());
                if (mq.size() == 0) m_etos = '0;
                n_cmp++;
                if (dut_state() !== exp_state()) begin
                    n_fail++;
                    $display("FAIL stream_pop[%0d]: got %h required %h", n_acc, dut_state(), exp_state());
                end
            end
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        n_cmp++;
        if (n_acc != 4 || empty !== 1'b1 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: pops=%0d empty=%b underflow=%b required 4 1 0", n_acc, empty, underflow);
        end
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 0; i < FULLC; i++) begin
            issue(PUSH, W'(16'hA000 + i), 1'b0);
            n_cmp++;
            if (cap_we !== exp_we || (exp_we && (cap_addr !== exp_addr || cap_wdata !== exp_wdata))) begin
                n_fail++;
                $display("FAIL fill_spill[%0d]: we=%b addr=%h wd=%h required %b %h %h",
                         i, cap_we, cap_addr, cap_wdata, exp_we, exp_addr, exp_wdata);
            end
        end
        n_cmp++;
        if (dut_state() !== exp_state() || count !== 10'd514 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_state: got %h required %h", dut_state(), exp_state());
        end
        issue(PUSH, 16'hDEAD, 1'b0);
        n_cmp++;
        if (cap_we !== 1'b0 || overflow !== 1'b1 || tos !== 16'hA201) begin
            n_fail++;
            $display("FAIL overflow_push: we=%b overflow=%b tos=%h required 0 1 a201", cap_we, overflow, tos);
        end
        for (int i = 0; i < FULLC; i++) begin
            issue(POP, '0, 1'b0);
            n_cmp++;
            if (dut_state() !== exp_state()) begin
                n_fail++;
                $display("FAIL drain[%0d]: got %h required %h", i, dut_state(), exp_state());
            end
        end
        n_cmp++;
        if (empty !== 1'b1 || underflow !== 1'b0 || tos !== 16'h0) begin
            n_fail++;
            $display("FAIL drain_end: empty=%b underflow=%b tos=%h required 1 0 0000", empty, underflow, tos);
        end
    endtask

    task automatic test_underflow_clr();
        apply_reset();
        issue(POP, '0, 1'b0);
        n_cmp++;
        if (underflow !== 1'b1 || count !== 10'd0 || dut_state() !== exp_state()) begin
            n_fail++;
            $display("FAIL underflow_set: underflow=%b count=%0d required 1 0", underflow, count);
        end
        issue(POP, '0, 1'b1);
        n_cmp++;
        if (underflow !== 1'b1 || dut_state() !== exp_state()) begin
            n_fail++;
            $display("FAIL underflow_set_wins: underflow=%b required 1", underflow);
        end
        issue(NOP, '0, 1'b1);
        n_cmp++;
        if (underflow !== 1'b0 || dut_state() !== exp_state()) begin
            n_fail++;
            $display("FAIL underflow_clear: underflow=%b required 0", underflow);
        end
    endtask

    task automatic test_replace_reset();
        logic [W-1:0] old_nos;
        apply_reset();
        for (int i = 0; i < 3; i++) issue(PUSH, W'($urandom), 1'b0);
        old_nos = m_nos();
        issue(REPL, 16'hBEEF, 1'b0);
        n_cmp++;
        if ({tos, nos, count} !== {16'hBEEF, old_nos, 10'd3} || dut_state() !== exp_state()) begin
            n_fail++;
            $display("FAIL replace: tos=%h nos=%h count=%0d required beef %h 3", tos, nos, count, old_nos);
        end
        issue(PUSH, 16'h7777, 1'b0);
        issue(POP, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({dut_state(), bus.cmd_ready} !== {16'h0, 16'h0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset: got %h required %h", {dut_state(), bus.cmd_ready},
                     {16'h0, 16'h0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        issue(PUSH, 16'h5A5A, 1'b0);
        n_cmp++;
        if ({tos, nos, count} !== {16'h5A5A, 16'h0, 10'd1}) begin
            n_fail++;
            $display("FAIL after_reset_push: tos=%h nos=%h count=%0d required 5a5a 0000 1", tos, nos, count);
        end
    endtask

    task automatic test_random();
        int           r;
        logic [1:0]   op;
        logic [W-1:0] data;
        bit           clr;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            r    = $urandom_range(0, 9);
            op   = (r <= 3 || r == 9) ? PUSH : (r <= 6) ? POP : (r == 7) ? REPL : NOP;
            data = W'($urandom);
            clr  = ($urandom_range(0, 15) == 0);
            issue(op, data, clr);
            n_cmp++;
            if (dut_state() !== exp_state()) begin
                n_fail++;
                $display("FAIL rand_state[%0d] op=%0d: got %h required %h", i, op, dut_state(), exp_state());
            end
            n_cmp++;
            if (cap_we !== exp_we || (exp_we && (cap_addr !== exp_addr || cap_wdata !== exp_wdata))) begin
                n_fail++;
                $display("FAIL rand_ram[%0d]: we=%b addr=%h wd=%h required %b %h %h",
                         i, cap_we, cap_addr, cap_wdata, exp_we, exp_addr, exp_wdata);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) mem[i] = '0;
        mem_addr_q = '0;
        model_reset();
        test_reset();
        test_push_basic();
        test_pop_stall();
        test_pop_stream();
        test_fill_overflow();
        test_underflow_clr();
        test_replace_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Hardware stack controller for the Forth core's data and return stacks.
- Sits directly upstream of the single-port 512x16 RAM instance and drives its address, write data and write enable.
- Caches top-of-stack (TOS) and next-on-stack (NOS) in registers. Deeper entries spill to and refill from the RAM.
- The RAM has 1-cycle read latency: the address is registered, then the data is read from the array.

Parameters:
- WIDTH, 16, stack word width.
- DEPTH, 512, number of RAM-backed entries.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width.
- CNT_WIDTH, $clog2(DEPTH+3), width of the occupancy count.

Ports:
- rst  input  1  asynchronous, active-high reset.
- clk_a  input  1  clock; shared with RAM port a.
- cmd_valid  input  1  command present.
- cmd_op  input  2  00 nop, 01 push, 10 pop, 11 replace.
- cmd_data  input  WIDTH  data for push/replace.
- cmd_ready  output  1  command can be accepted this cycle.
- clr_err  input  1  clears the sticky error flags.
- tos  output  WIDTH  top of stack (registered).
- nos  output  WIDTH  next on stack (registered).
- count  output  CNT_WIDTH  occupancy, 0..DEPTH+2.
- empty  output  1  count==0.
- full  output  1  count==DEPTH+2.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.
- ram_addr  output  ADDR_WIDTH  to RAM addr_a.
- ram_wdata  output  WIDTH  to RAM wdata_a.
- ram_we  output  1  to RAM write_en_a.
- ram_rdata  input  WIDTH  from RAM rdata_a.

Behaviour:
- Reset values (async): tos=0, nos=0, count=0, sp=0, overflow=0, underflow=0, cmd_ready=1, stall=0.
- Internal sp (ADDR_WIDTH+1 bits) = number of RAM-resident entries = max(count-2, 0).
- Acceptance: a command is accepted when cmd_valid && cmd_ready. Nop is always a no-op.
- Push, when not full:
  - count==0: tos<=cmd_data.
  - count==1: nos<=tos, tos<=cmd_data.
  - count>=2: RAM[sp]<=nos (ram_we=1, ram_addr=sp, ram_wdata=nos), nos<=tos, tos<=cmd_data, sp++.
  - In all cases count++.
- Push when full: no state change, ram_we=0, overflow<=1.
- Pop, when not empty:
  - count==1: tos<=0.
  - count==2: tos<=nos, nos<=0.
  - count>2: tos<=nos, nos<=ram_rdata, sp--.
  - In all cases count--.
- Pop when empty: no state change, underflow<=1.
- Replace: tos<=cmd_data; count unchanged. Allowed even when empty; count stays 0.
- RAM addressing:
  - ram_addr is combinational: sp[ADDR_WIDTH-1:0] for an accepted push, otherwise (sp-1) mod DEPTH.
  - ram_rdata therefore holds RAM[sp-1] one cycle after sp settles.
  - After a push the registered address equals new sp-1 and holds just-written data, so no stall is needed.
- Pop stall: cmd_ready goes low for exactly the cycle after any accepted pop, including underflow pops and pops with count<=2, while the RAM fetches the new sp-1. It is high otherwise.
- ram_we: asserted only for an accepted push with count>=2. ram_wdata=nos at all times.
- Error flags: clr_err clears overflow/underflow. If a new error and clr_err occur in the same cycle, the set wins. Flags do not block operation.
- RAM occupancy: at sp==DEPTH the RAM is full (full=1).
- Reset mid-operation: all state returns to reset values immediately. RAM contents are not cleared; they are logically discarded via count=0.

Test Plan:
- Reset, push 0x1111, 0x2222, 0x3333 on consecutive cycles -> tos=0x3333, nos=0x2222, count=3, one ram_we pulse with ram_addr=0, ram_wdata=0x1111.
- From that state, pop -> tos=0x2222, nos=0x1111, count=2, cmd_ready=0 next cycle. Pop again -> tos=0x1111, nos=0, count=1.
- Hold cmd_valid with op=pop continuously from count=4 -> accepted every other cycle, 4 pops in 8 cycles, data returned in LIFO order, then empty=1.
- Fill to count=DEPTH+2 (514) with an incrementing pattern, push once more -> overflow=1, tos unchanged, ram_we=0. Pop all 514 -> values in exact reverse order, no data corruption across sp wrap.
- Pop when empty -> underflow=1, count=0. Assert clr_err and a second empty pop in the same cycle -> underflow stays 1. clr_err alone -> 0.
- Replace 0xBEEF at count=3 -> tos=0xBEEF, nos and count unchanged. Assert rst mid-sequence -> all outputs at reset values, cmd_ready=1.
